// File: rtl/intersection_ctrl_if.sv
// Lamp-head and request bundle for the intersection controller.
// The master side drives the requests; the slave side drives the lamps.
interface intersection_ctrl_if;
    logic       ped_req;
    logic       emerg;
    logic       ns_red;
    logic       ns_blue;
    logic       ns_green;
    logic       ew_red;
    logic       ew_blue;
    logic       ew_green;
    logic       walk;
    logic [2:0] phase;

    modport master (
        output ped_req, emerg,
        input  ns_red, ns_blue, ns_green,
        input  ew_red, ew_blue, ew_green,
        input  walk, phase
    );

    modport slave (
        input  ped_req, emerg,
        output ns_red, ns_blue, ns_green,
        output ew_red, ew_blue, ew_green,
        output walk, phase
    );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-way intersection controller with pedestrian walk and emergency preempt.
// Moore lamps; one 32-bit down-counter times every phase.
module intersection_ctrl #(
    parameter int unsigned GREEN_TICKS = 50_000_000,
    parameter int unsigned BLUE_TICKS  = 20_000_000,
    parameter int unsigned CLEAR_TICKS = 10_000_000,
    parameter int unsigned WALK_TICKS  = 100_000_000
) (
    input logic                clk,
    input logic                rst_n,
    intersection_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        NS_GREEN   = 3'd0,
        NS_BLUE    = 3'd1,
        CLR_NS     = 3'd2,
        EW_GREEN   = 3'd3,
        EW_BLUE    = 3'd4,
        CLR_EW     = 3'd5,
        PED_WALK   = 3'd6,
        EMERG_HOLD = 3'd7
    } state_t;

    localparam logic [31:0] GREEN_LD = 32'(GREEN_TICKS - 1);
    localparam logic [31:0] BLUE_LD  = 32'(BLUE_TICKS - 1);
    localparam logic [31:0] CLEAR_LD = 32'(CLEAR_TICKS - 1);
    localparam logic [31:0] WALK_LD  = 32'(WALK_TICKS - 1);

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic        ped_pending, ped_nx;
    logic        dir, dir_nx;
    logic        expired;
    logic        walk_entry;

    assign expired    = (cnt == 32'd0);
    assign walk_entry = (state_nx == PED_WALK) && (state != PED_WALK);

    function automatic logic [31:0] load_of(state_t s);
        logic [31:0] v;
        v = 32'd0;
        unique case (s)
            NS_GREEN, EW_GREEN: v = GREEN_LD;
            NS_BLUE, EW_BLUE:   v = BLUE_LD;
            CLR_NS, CLR_EW:     v = CLEAR_LD;
            PED_WALK:           v = WALK_LD;
            default:            v = 32'd0;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLR_EW;
            cnt         <= CLEAR_LD;
            ped_pending <= 1'b0;
            dir         <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            ped_pending <= ped_nx;
            dir         <= dir_nx;
        end
    end

    // dir=1 means the walk was entered from CLR_NS, so EW is served next
    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        unique case (state)
            NS_GREEN: begin
                if (bus.emerg || expired) state_nx = NS_BLUE;
            end
            NS_BLUE: begin
                if (expired) state_nx = CLR_NS;
            end
            CLR_NS: begin
                if (expired) begin
                    if (bus.emerg) begin
                        state_nx = EMERG_HOLD;
                    end else if (ped_pending) begin
                        state_nx = PED_WALK;
                        dir_nx   = 1'b1;
                    end else begin
                        state_nx = EW_GREEN;
                    end
                end
            end
            EW_GREEN: begin
                if (bus.emerg || expired) state_nx = EW_BLUE;
            end
            EW_BLUE: begin
                if (expired) state_nx = CLR_EW;
            end
            CLR_EW: begin
                if (expired) begin
                    if (bus.emerg) begin
                        state_nx = EMERG_HOLD;
                    end else if (ped_pending) begin
                        state_nx = PED_WALK;
                        dir_nx   = 1'b0;
                    end else begin
                        state_nx = NS_GREEN;
                    end
                end
            end
            PED_WALK: begin
                if (bus.emerg) begin
                    state_nx = EMERG_HOLD;
                end else if (expired) begin
                    state_nx = dir ? EW_GREEN : NS_GREEN;
                end
            end
            EMERG_HOLD: begin
                if (!bus.emerg) state_nx = CLR_EW;
            end
            default: state_nx = CLR_EW;
        endcase
    end

    always_comb begin
        ped_nx = bus.ped_req | (ped_pending & ~walk_entry);
        cnt_nx = cnt;
        if (state_nx != state) begin
            cnt_nx = load_of(state_nx);
        end else if (state != EMERG_HOLD) begin
            cnt_nx = cnt - 32'd1;
        end
    end

    always_comb begin
        bus.ns_red   = 1'b1;
        bus.ns_blue  = 1'b0;
        bus.ns_green = 1'b0;
        bus.ew_red   = 1'b1;
        bus.ew_blue  = 1'b0;
        bus.ew_green = 1'b0;
        bus.walk     = 1'b0;
        bus.phase    = state;
        unique case (state)
            NS_GREEN: begin
                bus.ns_red   = 1'b0;
                bus.ns_green = 1'b1;
            end
            NS_BLUE: begin
                bus.ns_red  = 1'b0;
                bus.ns_blue = 1'b1;
            end
            EW_GREEN: begin
                bus.ew_red   = 1'b0;
                bus.ew_green = 1'b1;
            end
            EW_BLUE: begin
                bus.ew_red  = 1'b0;
                bus.ew_blue = 1'b1;
            end
            PED_WALK: bus.walk = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: directed scenarios plus random traffic,
// every edge compared against a phase/elapsed-time reference model.
module tb_intersection_ctrl;

    localparam int G = 5;
    localparam int B = 2;
    localparam int C = 1;
    localparam int W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    intersection_ctrl_if bus ();

    intersection_ctrl #(
        .GREEN_TICKS(G),
        .BLUE_TICKS (B),
        .CLEAR_TICKS(C),
        .WALK_TICKS (W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    int m_phase;
    int m_el;
    bit m_ped;
    bit m_dir;

    function automatic int dur(int p);
        case (p)
            0, 3:    return G;
            1, 4:    return B;
            2, 5:    return C;
            6:       return W;
            default: return 0;
        endcase
    endfunction

    function automatic logic [6:0] lamps_of(int p);
        logic nr, nb, ng, er, eb, eg, wk;
        ng = (p == 0);
        nb = (p == 1);
        nr = !(ng || nb);
        eg = (p == 3);
        eb = (p == 4);
        er = !(eg || eb);
        wk = (p == 6);
        return {nr, nb, ng, er, eb, eg, wk};
    endfunction

    function automatic logic [6:0] lamps_now();
        return {bus.ns_red, bus.ns_blue, bus.ns_green,
                bus.ew_red, bus.ew_blue, bus.ew_green, bus.walk};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 5;
        m_el    = 0;
        m_ped   = 0;
        m_dir   = 0;
    endtask

    task automatic model_edge(bit pr, bit em);
        int np;
        bit ex;
        np = m_phase;
        ex = (m_phase != 7) && (m_el + 1 >= dur(m_phase));
        case (m_phase)
            0, 3: if (em || ex) np = m_phase + 1;
            1, 4: if (ex) np = m_phase + 1;
            2, 5: begin
                if (ex) begin
                    if (em) np = 7;
                    else if (m_ped) begin
                        np    = 6;
                        m_dir = (m_phase == 2);
                    end else np = (m_phase == 2) ? 3 : 0;
                end
            end
            6: begin
                if (em) np = 7;
                else if (ex) np = m_dir ? 3 : 0;
            end
            default: if (!em) np = 5;
        endcase
        m_ped   = pr || (m_ped && !(np == 6 && m_phase != 6));
        m_el    = (np == m_phase) ? m_el + 1 : 0;
        m_phase = np;
    endtask

    task automatic step(bit pr, bit em);
        bus.ped_req = pr;
        bus.emerg   = em;
        @(posedge clk);
        model_edge(pr, em);
        #1;
        check("phase", 32'(bus.phase), 32'(m_phase));
        check("lamps", 32'(lamps_now()), 32'(lamps_of(m_phase)));
    endtask

    task automatic run_until(int p, int el);
        int n;
        n = 0;
        while (!(m_phase == p && m_el == el) && n < 100) begin
            step(0, 0);
            n++;
        end
        check("reach", 32'(n < 100), 32'd1);
    endtask

    task automatic do_reset();
        bus.ped_req = 1'b0;
        bus.emerg   = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #1;
        check("rst_phase", 32'(bus.phase), 32'd5);
        check("rst_lamps", 32'(lamps_now()), 32'(lamps_of(5)));
        @(posedge clk);
        #1;
        check("rst_hold", 32'(bus.phase), 32'd5);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(bus.ns_green && bus.ew_green)) else begin
                failures++;
                $error("FAIL both_green got=1 exp=0");
            end
        end
    end

    initial begin
        int seq [16];
        int wc;
        int entries;
        bit em_lvl;
        bit pr;
        seq = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5};
        bus.ped_req = 1'b0;
        bus.emerg   = 1'b0;
        #1;
        do_reset();

        // free run
        for (int i = 0; i < 32; i++) begin
            step(0, 0);
            check("freerun", 32'(bus.phase), 32'(seq[i % 16]));
        end

        // ped pulse in NS_GREEN
        run_until(0, 1);
        step(1, 0);
        wc = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0);
            if (bus.phase == 3'd6 && bus.walk && bus.ns_red && bus.ew_red)
                wc++;
        end
        check("ped_walk_len", 32'(wc), 32'd3);

        // emerg in 2nd cycle of EW_GREEN
        run_until(3, 1);
        step(0, 1);
        check("em_blue", 32'(bus.phase), 32'd4);
        for (int i = 0; i < 6; i++) step(0, 1);
        check("em_hold", 32'(bus.phase), 32'd7);
        step(0, 0);
        check("em_clr", 32'(bus.phase), 32'd5);
        step(0, 0);
        check("em_ns", 32'(bus.phase), 32'd0);

        // emerg in 2nd cycle of PED_WALK
        step(1, 0);
        run_until(6, 1);
        step(0, 1);
        check("walk_pre", 32'(bus.phase), 32'd7);
        check("walk_drop", 32'(bus.walk), 32'd0);
        step(0, 1);
        step(0, 0);

        // reset mid EW_GREEN discards pending request
        step(1, 0);
        run_until(3, 2);
        do_reset();
        step(0, 0);
        check("no_walk_rst", 32'(bus.phase == 3'd6), 32'd0);

        // ped held high
        entries = 0;
        for (int i = 0; i < 60; i++) begin
            step(1, 0);
            if (bus.phase == 3'd6 && m_el == 0) entries++;
        end
        check("walk_entries", 32'(entries >= 4), 32'd1);
        for (int i = 0; i < 30; i++) step(0, 0);

        // random traffic
        em_lvl = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                em_lvl = 0;
            end
            if ($urandom_range(0, 19) == 0) em_lvl = !em_lvl;
            pr = ($urandom_range(0, 9) == 0);
            step(pr, em_lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter GREEN_TICKS, default 50_000_000, green phase length in clk cycles (>=1).
REQ-002 SHALL have parameter BLUE_TICKS, default 20_000_000, blue (caution) phase length in clk cycles (>=1).
REQ-003 SHALL have parameter CLEAR_TICKS, default 10_000_000, all-red clearance length in clk cycles (>=1).
REQ-004 SHALL have parameter WALK_TICKS, default 100_000_000, pedestrian walk length in clk cycles (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ped_req  input  1  pedestrian request, synchronous to clk; a one-cycle pulse suffices.
REQ-008 SHALL have port emerg  input  1  emergency preempt level, synchronous to clk.
REQ-009 SHALL have ports ns_red, ns_blue, ns_green  output  1 each  north-south lamp head.
REQ-010 SHALL have ports ew_red, ew_blue, ew_green  output  1 each  east-west lamp head.
REQ-011 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-012 SHALL have port phase  output  3  current state: 0 NS_GREEN, 1 NS_BLUE, 2 CLR_NS, 3 EW_GREEN, 4 EW_BLUE, 5 CLR_EW, 6 PED_WALK, 7 EMERG_HOLD.

Function
REQ-013 SHALL decode all lamps from the current state register only (Moore), with no extra latency vs phase.
REQ-014 SHALL drive exactly one lamp per head high at all times; in every state other than NS_GREEN and NS_BLUE, ns_red=1; in every state other than EW_GREEN and EW_BLUE, ew_red=1.
REQ-015 SHALL assert walk only in PED_WALK.
REQ-016 SHALL use a 32-bit down-counter loaded with (ticks-1) of the entered state on every state entry; the state exits on the cycle in which counter==0, so each timed state lasts exactly its ticks in cycles.
REQ-017 SHALL sequence NS_GREEN->NS_BLUE->CLR_NS->EW_GREEN->EW_BLUE->CLR_EW->NS_GREEN with no inputs active.
REQ-018 SHALL set a ped_pending latch on any cycle with ped_req=1.
REQ-019 SHALL clear ped_pending on entry to PED_WALK; set wins if ped_req=1 in that same cycle.
REQ-020 SHALL, at expiry of CLR_NS or CLR_EW with ped_pending=1 and emerg=0, enter PED_WALK instead of the next green.
REQ-021 SHALL exit PED_WALK to EW_GREEN if entered from CLR_NS, and to NS_GREEN if entered from CLR_EW; one stored direction bit is sufficient.
REQ-022 SHALL, with emerg=1 in NS_GREEN or EW_GREEN, move on the next edge to that direction's BLUE state with a full BLUE_TICKS load.
REQ-023 SHALL, with emerg=1 in a BLUE state, finish the countdown normally.
REQ-024 SHALL, with emerg=1 at CLR_* expiry, enter EMERG_HOLD; emerg has priority over ped_pending, which is retained.
REQ-025 SHALL, with emerg=1 in PED_WALK, enter EMERG_HOLD on the next edge (walk drops).
REQ-026 SHALL hold EMERG_HOLD (all red, walk=0, counter idle) while emerg=1, and on the first cycle with emerg=0 enter CLR_EW with full CLEAR_TICKS load.
REQ-027 SHALL NOT modify the green/blue/clear durations based on ped_req; ped_req never shortens a green.

Reset
REQ-028 SHALL, while rst_n=0, force state CLR_EW, counter=CLEAR_TICKS-1, ped_pending=0, direction bit=0, regardless of clk.
REQ-029 SHALL present during reset: ns_red=1, ew_red=1, all blue/green=0, walk=0, phase=5.
REQ-030 SHALL discard any pending request and interrupted phase on reset mid-operation; operation resumes from CLR_EW on the first edge after release.

Verification (GREEN_TICKS=5, BLUE_TICKS=2, CLEAR_TICKS=1, WALK_TICKS=3)
REQ-031 SHALL cover free-run: release rst_n, inputs 0 -> phase 5 (1 cycle), 0 (5), 1 (2), 2 (1), 3 (5), 4 (2), 5 (1), repeating with a 16-cycle period.
REQ-032 SHALL cover a ped_req 1-cycle pulse in NS_GREEN -> CLR_NS 1 cycle, PED_WALK 3 cycles with walk=1 and both reds=1, then EW_GREEN 5 cycles.
REQ-033 SHALL cover emerg raised in cycle 2 of EW_GREEN -> EW_BLUE 2 cycles, CLR_EW 1 cycle, EMERG_HOLD while high; drop emerg -> CLR_EW 1 cycle -> NS_GREEN.
REQ-034 SHALL cover emerg raised in the 2nd cycle of PED_WALK -> phase=7 and walk=0 on the next edge.
REQ-035 SHALL cover a ped_req pulse, then rst_n low mid-EW_GREEN -> immediate all-red, phase=5; after release, no PED_WALK occurs in the first cycle.
REQ-036 SHALL cover ped_req held high -> PED_WALK after every CLR_* expiry, with lamps never showing green on both heads; a bench assertion checks this every cycle.
